eth_tx_stream_framer: RTL

- Upstream neighbour of the Ethernet RX/TX wrapper on the transmit side.
- Takes an unframed 512-bit application stream and cuts it into payload frames for the wrapper's tx payload port (s_axis_net_tx_*), which prepends the Ethernet header per tlast-delimited frame.
- Closes a frame on any of three events: a frame-size limit, an explicit upstream tlast, or an idle timeout. Partial data is never stranded.

---
 rtl/eth_tx_stream_framer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_stream_framer.sv
// eth_tx_stream_framer
//   Cuts an unframed application stream into tlast-delimited payload frames
//   for the Ethernet TX wrapper's payload port. A frame closes on whichever
//   comes first: the beat-count limit, an upstream tlast, or an idle timeout
//   on a held beat. A partial frame is never left stranded.
//
// Ports
//   ap_clk, ap_rst        clock, asynchronous active-high reset
//   s_axis_*              input stream (tdata/tkeep/tlast, valid/ready)
//   m_axis_*              framed output stream to the wrapper
//   stat_frames           frames emitted (tlast handshakes), wraps
//   stat_timeout_flushes  frames closed only by the idle timeout, wraps
//   busy                  hold register occupied
//
// Handshake: both sides use AXI4-Stream valid/ready. A beat transfers on a
// rising edge where valid and ready are both high; once valid is raised,
// data/keep/last are held stable until that transfer. s_axis_tready depends
// combinationally on m_axis_tready (pass-through of a full hold register).
module eth_tx_stream_framer #(
  parameter int DATA_WIDTH     = 512,
  parameter int MAX_BEATS      = 23,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_timeout_flushes,
  output logic                    busy
);

  localparam int KW = DATA_WIDTH / 8;
  // The timer counts 0..TIMEOUT_CYCLES-1; the flush is raised on the edge
  // that completes the last idle cycle.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

  // Hold register
  logic [DATA_WIDTH-1:0] h_data;
  logic [KW-1:0]         h_keep;
  logic                  h_last;
  logic                  h_valid;

  logic [7:0]    beat_cnt;
  logic [TW-1:0] timer;
  logic          flush_pend;

  logic in_data;
  logic succ;
  logic at_max;
  logic close;
  logic fire;
  logic accept;
  logic load;
  logic mark;
  logic timer_run;

  // Beats with tkeep == 0 carry no payload: they never count as a successor
  // for the held beat, so an empty tlast beat can still close the frame on
  // the beat already held instead of letting it leave without tlast.
  assign in_data   = (s_axis_tkeep != '0);
  assign succ      = s_axis_tvalid & in_data;
  assign at_max    = (beat_cnt == LAST_IDX);
  assign close     = h_last | at_max | flush_pend;

  // The held beat is released only when its successor is known to exist or
  // the frame is closing, so tlast is always decided at release time.
  assign m_axis_tvalid = h_valid & (succ | close);
  assign fire          = m_axis_tvalid & m_axis_tready;

  // With a beat held, input is taken only when the downstream can take the
  // held beat; for a data beat that is exactly a pass-through. Forced low
  // while reset is asserted.
  assign s_axis_tready = ~ap_rst & (~h_valid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign load          = accept & in_data;
  assign mark          = accept & ~in_data & s_axis_tlast & h_valid & ~fire;

  // Idle time only accrues while the held beat is not being offered.
  assign timer_run = h_valid & ~m_axis_tvalid;

  assign m_axis_tdata = h_data;
  assign m_axis_tkeep = h_keep;
  assign m_axis_tlast = h_valid & close;
  assign busy         = h_valid;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      h_data               <= '0;
      h_keep               <= '0;
      h_last               <= 1'b0;
      h_valid              <= 1'b0;
      beat_cnt             <= '0;
      timer                <= '0;
      flush_pend           <= 1'b0;
      stat_frames          <= '0;
      stat_timeout_flushes <= '0;
    end else begin
      // Hold register: load (possibly as pass-through), drain, or mark last
      if (load) begin
        h_data  <= s_axis_tdata;
        h_keep  <= s_axis_tkeep;
        h_last  <= s_axis_tlast;
        h_valid <= 1'b1;
      end else if (fire) begin
        h_valid <= 1'b0;
        h_last  <= 1'b0;
      end else if (mark) begin
        h_last <= 1'b1;
      end

      // Idle timer and pending flush; flush_pend persists until the beat goes
      if (load | fire) begin
        timer      <= '0;
        flush_pend <= 1'b0;
      end else if (TIMEOUT_EN && timer_run && !flush_pend) begin
        if (timer == TIMER_LAST) begin
          flush_pend <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end

      // Position of the held beat within the current frame
      if (fire) begin
        beat_cnt <= close ? 8'd0 : beat_cnt + 8'd1;
      end

      if (fire && close) begin
        stat_frames <= stat_frames + 32'd1;
        if (flush_pend && !h_last && !at_max) begin
          stat_timeout_flushes <= stat_timeout_flushes + 32'd1;
        end
      end
    end
  end

endmodule
